// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch sequencing controller: flag register, hazard wait, redirect handshake, statistics
module branch_ctrl #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              flag_n,
    input  logic              flag_v,
    input  logic              flag_z,
    input  logic              flag_pend,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              stall,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, REDIRECT} state_t;

    state_t            state;
    logic [2:0]        cond_q;
    logic [ADDR_W-1:0] target_q;
    logic              eff_n, eff_v, eff_z;
    logic              accept;
    logic              resolve;
    logic              taken;

    function automatic logic cond_met(input logic [2:0] c, input logic n, input logic v, input logic z);
        case (c)
            3'b000:  cond_met = ~z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = ~(z | n);
            3'b011:  cond_met = n;
            3'b100:  cond_met = z | ~n;
            3'b101:  cond_met = n | z;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    // A flag write in the same cycle is bypassed straight into the evaluation.
    assign eff_n = flag_we ? flag_n : N;
    assign eff_v = flag_we ? flag_v : V;
    assign eff_z = flag_we ? flag_z : Z;

    assign br_ready = (state == IDLE) & ~rst;
    assign stall    = (state != IDLE);
    assign accept   = br_valid & br_ready;

    always_comb begin
        resolve = 1'b0;
        taken   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (br_cond == 3'b111 || !flag_pend)) begin
                    resolve = 1'b1;
                    taken   = cond_met(br_cond, eff_n, eff_v, eff_z);
                end
            end
            WAIT_FLAGS: begin
                if (!flag_pend) begin
                    resolve = 1'b1;
                    taken   = cond_met(cond_q, eff_n, eff_v, eff_z);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            N              <= 1'b0;
            V              <= 1'b0;
            Z              <= 1'b0;
            cond_q         <= '0;
            target_q       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            br_count       <= '0;
            taken_count    <= '0;
        end else begin
            if (flag_we) begin
                N <= flag_n;
                V <= flag_v;
                Z <= flag_z;
            end
            flush <= 1'b0;
            if (resolve && br_count != '1)
                br_count <= br_count + 1'b1;
            if (resolve && taken && taken_count != '1)
                taken_count <= taken_count + 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cond_q   <= br_cond;
                        target_q <= br_target;
                        if (resolve && taken) begin
                            state          <= REDIRECT;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= br_target;
                            flush          <= 1'b1;
                        end else if (!resolve) begin
                            state <= WAIT_FLAGS;
                        end
                    end
                end
                WAIT_FLAGS: begin
                    if (resolve) begin
                        if (taken) begin
                            state          <= REDIRECT;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= target_q;
                            flush          <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
